// File: rtl/bru_pkg.sv
// Shared definitions for the branch resolve unit: branch opcodes, the squash
// FSM state encoding and the offset sign-extension helper.
package bru_pkg;

   // Branch operation codes carried on brOp.
   localparam logic [2:0] OP_BR      = 3'd0;  // always taken
   localparam logic [2:0] OP_BMI     = 3'd1;  // rs negative
   localparam logic [2:0] OP_BPL     = 3'd2;  // rs strictly positive
   localparam logic [2:0] OP_BZ      = 3'd3;  // rs zero
   localparam logic [2:0] OP_BNZ     = 3'd4;  // rs non-zero
   localparam logic [2:0] OP_BEQ     = 3'd5;  // rs == rt
   localparam logic [2:0] OP_BNE     = 3'd6;  // rs != rt
   localparam logic [2:0] OP_ILLEGAL = 3'd7;  // undefined encoding

   // Widest offset / PC the sign-extension helper supports.
   localparam int BRU_MAX_W = 64;

   // Squash FSM: RUN passes results through, SQUASH drops wrong-path requests.
   typedef enum logic {
      RUN    = 1'b0,
      SQUASH = 1'b1
   } bru_state_e;

   // Sign-extend the low off_w bits of off to BRU_MAX_W bits; callers truncate
   // the result to their own PC width.
   function automatic logic [BRU_MAX_W-1:0] sext_offset(
      input logic [BRU_MAX_W-1:0] off,
      input int unsigned          off_w
   );
      logic [BRU_MAX_W-1:0] upper_mask;
      logic [BRU_MAX_W-1:0] sign_shifted;
      upper_mask   = {BRU_MAX_W{1'b1}} << off_w;
      sign_shifted = off >> (off_w - 1);
      return sign_shifted[0] ? (off | upper_mask) : (off & ~upper_mask);
   endfunction

endpackage

// File: rtl/bru_cond_eval.sv
// Combinational branch condition evaluator: decides taken/illegal from the
// opcode and the two register operands.
module bru_cond_eval
   import bru_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [2:0]        brOp,
   input  logic [DATA_W-1:0] rsOut,
   input  logic [DATA_W-1:0] rtOut,
   output logic              taken,
   output logic              illegal
);

   logic rs_zero;
   logic rs_neg;
   logic rs_eq_rt;

   assign rs_zero  = (rsOut == '0);
   assign rs_neg   = rsOut[DATA_W-1];
   assign rs_eq_rt = (rsOut == rtOut);

   // Decode the opcode into the taken decision; undefined codes flag illegal.
   always_comb begin
      // NOTE: every output gets a default before the case so no path leaves it
      // unassigned, which would otherwise infer a latch.
      taken   = 1'b0;
      illegal = 1'b0;
      case (brOp)
         OP_BR:   taken = 1'b1;
         OP_BMI:  taken = rs_neg;
         OP_BPL:  taken = !rs_neg && !rs_zero;
         OP_BZ:   taken = rs_zero;
         OP_BNZ:  taken = !rs_zero;
         OP_BEQ:  taken = rs_eq_rt;
         OP_BNE:  taken = !rs_eq_rt;
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolution stage: evaluates the branch condition, computes
// pc + sext(offset), registers the result behind a valid/ready handshake and
// drops SQUASH_CNT wrong-path requests after a taken branch.
// Optional feature: define BRU_STATS_EN to add saturating result counters
// stat_total / stat_taken.
module branch_resolve_unit
   import bru_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int PC_W       = 32,
   parameter int OFF_W      = 16,
   parameter int SQUASH_CNT = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        brOp,
   input  logic [DATA_W-1:0] rsOut,
   input  logic [DATA_W-1:0] rtOut,
   input  logic [PC_W-1:0]   pc,
   input  logic [OFF_W-1:0]  offset,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              isBranch,
   output logic [PC_W-1:0]   target,
   output logic              illegal,
   output logic              squashing
`ifdef BRU_STATS_EN
   ,
   output logic [31:0]       stat_total,
   output logic [31:0]       stat_taken
`endif
);

   localparam int CNT_W = (SQUASH_CNT > 1) ? $clog2(SQUASH_CNT + 1) : 1;

   bru_state_e        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              accept;
   logic              load;
   logic              cond_taken;
   logic              cond_illegal;
   logic [PC_W-1:0]   target_d;

   bru_cond_eval #(
      .DATA_W (DATA_W)
   ) u_cond (
      .brOp    (brOp),
      .rsOut   (rsOut),
      .rtOut   (rtOut),
      .taken   (cond_taken),
      .illegal (cond_illegal)
   );

   // Target is computed for every op; overflow wraps silently at PC_W bits.
   assign target_d = pc + PC_W'(sext_offset(BRU_MAX_W'(offset), OFF_W));

   // While squashing, requests are always swallowed regardless of the output
   // register. Otherwise ready follows the consumer directly (no skid buffer).
   assign in_ready  = (state_q == SQUASH) || !out_valid || out_ready;
   assign accept    = in_valid && in_ready;
   assign load      = accept && (state_q == RUN);
   assign squashing = (state_q == SQUASH);

   // Output register: load on accept in RUN, drop valid once consumed.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of block ordering.
      if (rst) begin
         out_valid <= 1'b0;
         isBranch  <= 1'b0;
         target    <= '0;
         illegal   <= 1'b0;
      end else if (load) begin
         out_valid <= 1'b1;
         isBranch  <= cond_taken;
         target    <= target_d;
         illegal   <= cond_illegal;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   // Squash FSM state and drop counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RUN;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Squash FSM next state: arm on a loaded taken branch, count down per drop.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         RUN: begin
            // Illegal ops never report taken, so they can never arm a squash.
            if (load && cond_taken && (SQUASH_CNT > 0)) begin
               state_d = SQUASH;
               cnt_d   = CNT_W'(SQUASH_CNT);
            end
         end
         SQUASH: begin
            if (accept) begin
               cnt_d = cnt_q - 1'b1;
               if (cnt_q == CNT_W'(1)) begin
                  state_d = RUN;
               end
            end
         end
         default: state_d = RUN;
      endcase
   end

`ifdef BRU_STATS_EN
   // Saturating counters of produced and taken results, bumped on load.
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_total <= '0;
         stat_taken <= '0;
      end else if (load) begin
         if (stat_total != '1) begin
            stat_total <= stat_total + 32'd1;
         end
         if (cond_taken && (stat_taken != '1)) begin
            stat_taken <= stat_taken + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit. Two instances share stimulus:
// u0 with SQUASH_CNT=2 and u1 with SQUASH_CNT=0. A behavioural model tracks
// each one and is compared every cycle; directed steps add literal checks.
module tb_branch_resolve_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [2:0]  brOp;
   logic [31:0] rsOut;
   logic [31:0] rtOut;
   logic [31:0] pc;
   logic [15:0] offset;
   logic        out_ready;

   logic        d_in_ready  [2];
   logic        d_out_valid [2];
   logic        d_isBranch  [2];
   logic [31:0] d_target    [2];
   logic        d_illegal   [2];
   logic        d_squashing [2];
`ifdef BRU_STATS_EN
   logic [31:0] d_stat_total [2];
   logic [31:0] d_stat_taken [2];
`endif

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   branch_resolve_unit #(.SQUASH_CNT(2)) u0 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (d_in_ready[0]),
      .brOp      (brOp),
      .rsOut     (rsOut),
      .rtOut     (rtOut),
      .pc        (pc),
      .offset    (offset),
      .out_valid (d_out_valid[0]),
      .out_ready (out_ready),
      .isBranch  (d_isBranch[0]),
      .target    (d_target[0]),
      .illegal   (d_illegal[0]),
      .squashing (d_squashing[0])
`ifdef BRU_STATS_EN
      ,
      .stat_total (d_stat_total[0]),
      .stat_taken (d_stat_taken[0])
`endif
   );

   branch_resolve_unit #(.SQUASH_CNT(0)) u1 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (d_in_ready[1]),
      .brOp      (brOp),
      .rsOut     (rsOut),
      .rtOut     (rtOut),
      .pc        (pc),
      .offset    (offset),
      .out_valid (d_out_valid[1]),
      .out_ready (out_ready),
      .isBranch  (d_isBranch[1]),
      .target    (d_target[1]),
      .illegal   (d_illegal[1]),
      .squashing (d_squashing[1])
`ifdef BRU_STATS_EN
      ,
      .stat_total (d_stat_total[1]),
      .stat_taken (d_stat_taken[1])
`endif
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   function automatic int sq_of(input int k);
      return (k == 0) ? 2 : 0;
   endfunction

   function automatic logic model_taken(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
      case (op)
         3'd0:    return 1'b1;
         3'd1:    return $signed(rs) < 0;
         3'd2:    return $signed(rs) > 0;
         3'd3:    return rs == 32'd0;
         3'd4:    return rs != 32'd0;
         3'd5:    return rs == rt;
         3'd6:    return rs != rt;
         default: return 1'b0;
      endcase
   endfunction

   logic        m_valid   [2];
   logic        m_taken   [2];
   logic [31:0] m_target  [2];
   logic        m_illegal [2];
   int          m_drops   [2];
   int          m_total   [2];
   int          m_ntaken  [2];
   logic        m_rdy;
   logic        m_acc;

   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            m_valid[k]   = 1'b0;
            m_taken[k]   = 1'b0;
            m_target[k]  = 32'd0;
            m_illegal[k] = 1'b0;
            m_drops[k]   = 0;
            m_total[k]   = 0;
            m_ntaken[k]  = 0;
         end else begin
            m_rdy = (m_drops[k] > 0) || !m_valid[k] || out_ready;
            m_acc = in_valid && m_rdy;
            if (m_drops[k] > 0) begin
               if (m_acc) m_drops[k]--;
               if (m_valid[k] && out_ready) m_valid[k] = 1'b0;
            end else if (m_acc) begin
               m_valid[k]   = 1'b1;
               m_taken[k]   = model_taken(brOp, rsOut, rtOut);
               m_illegal[k] = (brOp == 3'd7);
               m_target[k]  = pc + 32'(signed'(offset));
               m_total[k]++;
               if (m_taken[k]) m_ntaken[k]++;
               if (m_taken[k] && sq_of(k) > 0) m_drops[k] = sq_of(k);
            end else if (m_valid[k] && out_ready) begin
               m_valid[k] = 1'b0;
            end
         end
      end
      #2;
      for (int k = 0; k < 2; k++) begin
         check($sformatf("u%0d out_valid", k), 64'(d_out_valid[k]), 64'(m_valid[k]));
         check($sformatf("u%0d squashing", k), 64'(d_squashing[k]), 64'(m_drops[k] > 0));
         check($sformatf("u%0d in_ready", k), 64'(d_in_ready[k]),
               64'((m_drops[k] > 0) || !m_valid[k] || out_ready));
         if (m_valid[k]) begin
            check($sformatf("u%0d isBranch", k), 64'(d_isBranch[k]), 64'(m_taken[k]));
            check($sformatf("u%0d target", k), 64'(d_target[k]), 64'(m_target[k]));
            check($sformatf("u%0d illegal", k), 64'(d_illegal[k]), 64'(m_illegal[k]));
         end
`ifdef BRU_STATS_EN
         check($sformatf("u%0d stat_total", k), 64'(d_stat_total[k]), 64'(m_total[k]));
         check($sformatf("u%0d stat_taken", k), 64'(d_stat_taken[k]), 64'(m_ntaken[k]));
`endif
      end
   end

   // ---------------- stimulus ----------------
   task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] rs,
                        input logic [31:0] rt, input logic [31:0] pc_i,
                        input logic [15:0] off, input logic ordy);
      @(negedge clk);
      in_valid  = v;
      brOp      = op;
      rsOut     = rs;
      rtOut     = rt;
      pc        = pc_i;
      offset    = off;
      out_ready = ordy;
   endtask

   task automatic settle();
      @(posedge clk);
      #3;
   endtask

   task automatic cycle(input logic v, input logic [2:0] op, input logic [31:0] rs,
                        input logic [31:0] rt, input logic [31:0] pc_i,
                        input logic [15:0] off, input logic ordy);
      drive(v, op, rs, rt, pc_i, off, ordy);
      settle();
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; brOp = 3'd0; rsOut = '0; rtOut = '0;
      pc = '0; offset = '0; out_ready = 1'b1;

      // Reset state
      cycle(1'b0, 3'd0, 0, 0, 0, 16'h0, 1'b1);
      cycle(1'b0, 3'd0, 0, 0, 0, 16'h0, 1'b1);
      check("rst out_valid", 64'(d_out_valid[0]), 64'd0);
      check("rst isBranch", 64'(d_isBranch[0]), 64'd0);
      check("rst target", 64'(d_target[0]), 64'd0);
      check("rst illegal", 64'(d_illegal[0]), 64'd0);
      check("rst squashing", 64'(d_squashing[0]), 64'd0);
      rst = 1'b0;

      // BZ taken: result next cycle, squash armed on u0 only
      cycle(1'b1, 3'd3, 32'd0, 0, 32'h100, 16'h0004, 1'b1);
      check("bz out_valid", 64'(d_out_valid[0]), 64'd1);
      check("bz isBranch", 64'(d_isBranch[0]), 64'd1);
      check("bz target", 64'(d_target[0]), 64'h104);
      check("bz squashing", 64'(d_squashing[0]), 64'd1);
      check("bz u1 squashing", 64'(d_squashing[1]), 64'd0);

      // BPL / BMI on u1 (no squash); u0 drops the first two
      cycle(1'b1, 3'd2, 32'd0, 0, 32'h10, 16'h0, 1'b1);
      check("bpl0 isBranch", 64'(d_isBranch[1]), 64'd0);
      check("drop1 u0 out_valid", 64'(d_out_valid[0]), 64'd0);
      cycle(1'b1, 3'd2, 32'h8000_0000, 0, 32'h10, 16'h0, 1'b1);
      check("bpl_neg isBranch", 64'(d_isBranch[1]), 64'd0);
      check("drop2 u0 squashing", 64'(d_squashing[0]), 64'd0);
      cycle(1'b1, 3'd2, 32'd5, 0, 32'h10, 16'h0, 1'b1);
      check("bpl5 isBranch", 64'(d_isBranch[1]), 64'd1);
      cycle(1'b1, 3'd1, 32'h8000_0000, 0, 32'h10, 16'h0, 1'b1);
      check("bmi isBranch", 64'(d_isBranch[1]), 64'd1);

      // Target wrap-around
      cycle(1'b1, 3'd0, 0, 0, 32'h0000_0002, 16'hFFFC, 1'b1);
      check("wrap_neg target", 64'(d_target[1]), 64'hFFFF_FFFE);
      cycle(1'b1, 3'd3, 32'd7, 0, 32'hFFFF_FFFF, 16'h0001, 1'b1);
      check("wrap_pos target", 64'(d_target[0]), 64'h0);
      check("wrap_pos isBranch", 64'(d_isBranch[0]), 64'd0);

      // Backpressure: BNE not taken loaded, then consumer stalls 3 cycles
      cycle(1'b1, 3'd6, 32'd3, 32'd3, 32'h300, 16'h0010, 1'b1);
      for (int i = 0; i < 3; i++) begin
         cycle(1'b1, 3'd5, 32'd9, 32'd9, 32'h200, 16'h0020, 1'b0);
         check("stall in_ready", 64'(d_in_ready[0]), 64'd0);
         check("stall out_valid", 64'(d_out_valid[0]), 64'd1);
         check("stall target", 64'(d_target[0]), 64'h310);
         check("stall isBranch", 64'(d_isBranch[0]), 64'd0);
      end
      drive(1'b1, 3'd5, 32'd9, 32'd9, 32'h200, 16'h0020, 1'b1);
      #1;
      check("release in_ready", 64'(d_in_ready[0]), 64'd1);
      settle();
      check("beq target", 64'(d_target[0]), 64'h220);
      check("beq isBranch", 64'(d_isBranch[0]), 64'd1);
      check("beq squashing", 64'(d_squashing[0]), 64'd1);

      // Squash with gaps 1,0,1,1 on u0
      cycle(1'b1, 3'd0, 0, 0, 32'h500, 16'h0, 1'b1);
      check("gap drop1 out_valid", 64'(d_out_valid[0]), 64'd0);
      check("gap drop1 squashing", 64'(d_squashing[0]), 64'd1);
      cycle(1'b0, 3'd0, 0, 0, 32'h500, 16'h0, 1'b1);
      check("gap idle squashing", 64'(d_squashing[0]), 64'd1);
      cycle(1'b1, 3'd0, 0, 0, 32'h600, 16'h0, 1'b1);
      check("gap drop2 out_valid", 64'(d_out_valid[0]), 64'd0);
      check("gap drop2 squashing", 64'(d_squashing[0]), 64'd0);
      cycle(1'b1, 3'd3, 32'd5, 0, 32'h400, 16'h0, 1'b1);
      check("gap pass out_valid", 64'(d_out_valid[0]), 64'd1);
      check("gap pass target", 64'(d_target[0]), 64'h400);

      // Reset mid-squash
      cycle(1'b1, 3'd0, 0, 0, 32'h0, 16'h0008, 1'b1);
      cycle(1'b1, 3'd4, 32'd0, 0, 32'h0, 16'h0, 1'b1);
      check("midsq squashing", 64'(d_squashing[0]), 64'd1);
      rst = 1'b1;
      cycle(1'b0, 3'd0, 0, 0, 0, 16'h0, 1'b1);
      check("midsq rst squashing", 64'(d_squashing[0]), 64'd0);
      check("midsq rst out_valid", 64'(d_out_valid[0]), 64'd0);
      rst = 1'b0;

      // Illegal opcode
      cycle(1'b1, 3'd7, 0, 0, 32'h40, 16'hFFFF, 1'b1);
      check("ill out_valid", 64'(d_out_valid[0]), 64'd1);
      check("ill illegal", 64'(d_illegal[0]), 64'd1);
      check("ill isBranch", 64'(d_isBranch[0]), 64'd0);
      check("ill squashing", 64'(d_squashing[0]), 64'd0);
      check("ill target", 64'(d_target[0]), 64'h3F);

      // Five results on u1, two taken
      rst = 1'b1;
      cycle(1'b0, 3'd0, 0, 0, 0, 16'h0, 1'b1);
      rst = 1'b0;
      cycle(1'b1, 3'd0, 0, 0, 32'h10, 16'h0, 1'b1);
      cycle(1'b1, 3'd3, 32'd1, 0, 32'h14, 16'h0, 1'b1);
      cycle(1'b1, 3'd4, 32'd1, 0, 32'h18, 16'h0, 1'b1);
      cycle(1'b1, 3'd7, 32'd1, 0, 32'h1C, 16'h0, 1'b1);
      cycle(1'b1, 3'd5, 32'd1, 32'd2, 32'h20, 16'h0, 1'b1);
      cycle(1'b0, 3'd0, 0, 0, 0, 16'h0, 1'b1);
      check("drain out_valid", 64'(d_out_valid[1]), 64'd0);
`ifdef BRU_STATS_EN
      check("stat_total", 64'(d_stat_total[1]), 64'd5);
      check("stat_taken", 64'(d_stat_taken[1]), 64'd2);
`endif

      cycle(1'b0, 3'd0, 0, 0, 0, 16'h0, 1'b1);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
